bcd_countdown_timer: RTL
========================

// Module: bcd_countdown_timer
// PURPOSE
// Multi-digit BCD countdown timer for game rounds. It chains NDIGITS decade down-counters with internal borrow.
// It adds load, start/pause, bonus-time add, optional auto-reload and expiry flags.
// Sits between the one-second tick generator and the 7-segment display/game-control FSM.
// PARAMETERS
// NDIGITS      2    number of BCD digits (1..8); digit 0 = least significant
// BONUS        5    BCD value (0..9) added to digit 0 on each bonus_in pulse
// AUTO_RELOAD  0    1: on expiry reload the last loaded value and keep running
// PORTS
// clk          in   1          system clock
// rst          in   1          reset; synchronous, active-low
// tick_in      in   1          1-cycle pulse, one count unit (1 s)
// load_in      in   1          latch load_val into count and reload register
// load_val     in   4*NDIGITS  BCD preset, digit i at [4i+3:4i]
// start_in     in   1          IDLE/PAUSED -> RUN
// pause_in     in   1          RUN -> PAUSED
// bonus_in     in   1          add BONUS to count (saturating)
// count        out  4*NDIGITS  current BCD value
// running      out  1          1 while state == RUN
// expired      out  1          level, 1 in EXPIRED state
// expire_pulse out  1          1-cycle pulse on the tick that reaches zero
// BEHAVIOUR
// Reset (rst==0 at clk edge): count=0, reload reg=0, state=IDLE, running=0, expired=0, expire_pulse=0.
// States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered. Latency is 1 clk from input to count.
// Priority per cycle: rst > load_in > bonus_in > start/pause > tick_in.
// load_in: any state -> count=load_val, reload=load_val, state=IDLE, expired=0.
//   Any load digit >9 is clamped to 9.
// start_in: IDLE/PAUSED -> RUN if count!=0; if count==0 go to EXPIRED (expire_pulse=1).
//   Ignored in RUN/EXPIRED.
// pause_in: RUN -> PAUSED; ignored elsewhere. start_in and pause_in together -> ignore both.
// tick_in in RUN only: decrement by 1 with BCD borrow (digit 0 -> 9 borrows from next digit).
//   Ticks in other states are dropped.
//   Tick when count==1 (value, not digit): count=0, expire_pulse=1, state=EXPIRED.
//   If AUTO_RELOAD==1: count=reload, state stays RUN, expire_pulse=1, expired stays 0.
//     With reload==0 the block goes to EXPIRED instead.
// bonus_in: legal in IDLE/RUN/PAUSED. Count += BONUS with BCD carry.
//   If the result exceeds all-9s, it saturates to all-9s.
//   In EXPIRED, bonus_in is ignored (round is over).
//   Bonus and tick in the same cycle: bonus applied, that tick dropped.
// EXPIRED: holds count=0, expired=1 until load_in or reset. start_in is ignored.
// expire_pulse is high exactly one cycle and never asserts in the same cycle as reset or load.
// count digits are always valid BCD (0..9) in every cycle after reset.
// TESTING
// Reset, load 0x25, start, 25 ticks -> count 0x24..0x00; expire_pulse once on 25th tick; expired=1.
// count=0x10 RUN, tick -> 0x09 (borrow); NDIGITS=4, 0x1000 tick -> 0x0999.
// RUN at 0x07, pause, 3 ticks -> holds 0x07; start, tick -> 0x06.
// count=0x97 bonus(5) -> 0x99 saturate; 0x38 bonus -> 0x43; bonus+tick same cycle at 0x20 -> 0x25.
// AUTO_RELOAD=1, load 0x03, start, 3 ticks -> 0x02,0x01,0x03, pulse on 3rd; running stays 1.
// load 0xAF -> count 0x99; load mid-RUN resets to IDLE; rst low mid-RUN -> all outputs 0 next edge.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
// Multi-digit BCD countdown timer for game rounds. NDIGITS decade down-counters
// chained by borrow, with load (digits clamped to 9), start/pause, saturating
// bonus-time add, optional auto-reload on expiry and expiry flags.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active low
//   tick_in      one count unit (1-cycle pulse)
//   load_in      latch load_val into count and reload register, go IDLE
//   load_val     BCD preset, digit i at [4i+3:4i]
//   start_in     IDLE/PAUSED -> RUN (or EXPIRED when count is zero)
//   pause_in     RUN -> PAUSED
//   bonus_in     count += BONUS, saturating at all-9s (ignored when expired)
//   count        current BCD value
//   running      state is RUN
//   expired      state is EXPIRED
//   expire_pulse one cycle when the count runs out
//
// Per cycle only the highest-priority effective command acts:
// load > bonus > start/pause > tick. A start or pause that is ignored in the
// current state (or both asserted together) does not block a tick.
module bcd_countdown_timer #(
    parameter int NDIGITS     = 2,
    parameter int BONUS       = 5,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_in,
    input  logic                   load_in,
    input  logic [4*NDIGITS-1:0]   load_val,
    input  logic                   start_in,
    input  logic                   pause_in,
    input  logic                   bonus_in,
    output logic [4*NDIGITS-1:0]   count,
    output logic                   running,
    output logic                   expired,
    output logic                   expire_pulse
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam logic [3:0]               BONUS_D = 4'(BONUS);
    localparam logic [NDIGITS-1:0][3:0]  ALL9    = {NDIGITS{4'd9}};
    localparam logic [4*NDIGITS-1:0]     ONE     = {{(4*NDIGITS-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    logic [NDIGITS-1:0][3:0] cnt, cnt_nxt, rld, rld_nxt;
    logic [NDIGITS-1:0][3:0] load_clamp, cnt_dec, cnt_add;
    logic [NDIGITS:0]        borrow, carry;
    logic                    pulse_nxt, start_ok, pause_ok, cnt_zero, cnt_one;

    // Digit 0 always receives the decrement borrow; the bonus enters digit 0
    // as an addend, so no carry comes in from below.
    assign borrow[0] = 1'b1;
    assign carry[0]  = 1'b0;

    genvar i;
    generate
        for (i = 0; i < NDIGITS; i++) begin : g_digit
            logic [3:0] ld;
            logic [3:0] addend;
            logic [4:0] sum;

            assign ld            = load_val[4*i +: 4];
            assign load_clamp[i] = (ld > 4'd9) ? 4'd9 : ld;

            assign cnt_dec[i]  = !borrow[i]        ? cnt[i] :
                                 (cnt[i] == 4'd0)  ? 4'd9   : cnt[i] - 4'd1;
            assign borrow[i+1] = borrow[i] && (cnt[i] == 4'd0);

            assign addend       = (i == 0) ? BONUS_D : 4'd0;
            assign sum          = {1'b0, cnt[i]} + {1'b0, addend} + {4'd0, carry[i]};
            assign carry[i+1]   = (sum > 5'd9);
            assign cnt_add[i]   = (sum > 5'd9) ? 4'(sum - 5'd10) : sum[3:0];
        end
    endgenerate

    assign cnt_zero = (cnt == '0);
    assign cnt_one  = (cnt == ONE);
    assign start_ok = start_in && !pause_in && (state == IDLE || state == PAUSED);
    assign pause_ok = pause_in && !start_in && (state == RUN);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rld_nxt   = rld;
        pulse_nxt = 1'b0;
        if (load_in) begin
            cnt_nxt   = load_clamp;
            rld_nxt   = load_clamp;
            state_nxt = IDLE;
        end else if (bonus_in && state != EXPIRED) begin
            // carry out of the top digit means the sum passed all-9s
            cnt_nxt = carry[NDIGITS] ? ALL9 : cnt_add;
        end else if (start_ok) begin
            if (cnt_zero) begin
                state_nxt = EXPIRED;
                pulse_nxt = 1'b1;
            end else begin
                state_nxt = RUN;
            end
        end else if (pause_ok) begin
            state_nxt = PAUSED;
        end else if (tick_in && state == RUN) begin
            // zero cannot normally be held in RUN; treat it as expiry too
            if (cnt_one || cnt_zero) begin
                pulse_nxt = 1'b1;
                if (AUTO_RELOAD && rld != '0) begin
                    cnt_nxt = rld;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = EXPIRED;
                end
            end else begin
                cnt_nxt = cnt_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rld          <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rld          <= rld_nxt;
            running      <= (state_nxt == RUN);
            expired      <= (state_nxt == EXPIRED);
            expire_pulse <= pulse_nxt;
        end
    end

    assign count = cnt;

endmodule
